pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer with an integrated return-address stack; successor to the fixed-width PC block.
- Adds configurable PC/stack width, a pipeline stall input, interrupt entry/return (RETI), and sticky stack overflow/underflow flags.
- Sits between instruction decode and instruction memory and drives the fetch address every cycle.

Parameters:
- PC_WIDTH, 8, width of pc, instructionValue and stack entries.
- REGISTER_WIDTH, 8, width of the condition register input.
- OPCODE_WIDTH, 4, width of the opcode input.
- STACK_DEPTH, 16, number of return-stack entries; power of two, at least 2.
- RESET_VECTOR, 0, pc value after any reset.
- IRQ_VECTOR, 8'hF0, pc value on interrupt entry.
- OP_RESET/OP_JUMP/OP_CALL/OP_RET/OP_IF0JUMP/OP_IF1JUMP/OP_RETI, 0/1/2/3/4/5/6, opcode encodings; every other value means advance.

Ports:
- clock  in  1  rising-edge clock.
- resetN  in  1  asynchronous active-low reset.
- enable  in  1  1 = execute this cycle; 0 = stall, all state holds.
- opcode  in  OPCODE_WIDTH  decoded opcode of the instruction at pc.
- instructionValue  in  PC_WIDTH  branch/call target.
- registerValue  in  REGISTER_WIDTH  condition operand for the IF* opcodes.
- irq  in  1  level interrupt request.
- pc  out  PC_WIDTH  current fetch address (registered).
- stackCount  out  clog2(STACK_DEPTH)+1  number of valid stack entries.
- irqActive  out  1  set while an interrupt handler is running.
- stackOverflow  out  1  sticky; a push was attempted while the stack was full.
- stackUnderflow  out  1  sticky; a pop was attempted while the stack was empty.

Behaviour:
- Async reset (resetN=0): pc=RESET_VECTOR, stackCount=0, irqActive=0, both flags 0. Stack contents are don't-care.
- All updates happen on the rising edge of clock. pc is registered: an opcode presented in cycle N takes effect at the edge ending cycle N (1-cycle latency).
- enable=0: no state changes. A pending irq stays pending because irq is level-sensitive.
- Priority when enable=1, highest first: OP_RESET > interrupt entry > other opcodes.
- OP_RESET: synchronous soft reset; loads the same values as async reset, including clearing the sticky flags.
- Interrupt entry: taken when irq=1, irqActive=0 and opcode is not OP_RESET.
  - Push the current pc; the instruction at pc is not executed and is re-fetched on return.
  - pc <= IRQ_VECTOR; irqActive <= 1.
  - No nesting: irq is ignored while irqActive=1.
- OP_JUMP: pc <= instructionValue.
- OP_CALL: push pc+1, then pc <= instructionValue.
- OP_IF0JUMP: pc <= instructionValue if registerValue==0, else pc+1.
- OP_IF1JUMP: pc <= instructionValue if registerValue!=0, else pc+1.
- OP_RET: pop the top entry into pc.
- OP_RETI: pop the top entry into pc; irqActive <= 0.
- Any other opcode: pc <= pc+1.
- pc+1 wraps modulo 2^PC_WIDTH (all-ones -> 0).
- Stack is LIFO: push writes entry[stackCount] and increments stackCount; pop reads entry[stackCount-1] and decrements.
- Push when stackCount==STACK_DEPTH:
  - stackOverflow <= 1; no write, count unchanged.
  - pc still jumps (to the call target or IRQ_VECTOR); irqActive still set on interrupt entry.
- Pop when stackCount==0:
  - stackUnderflow <= 1; count unchanged; pc <= pc+1.
  - OP_RETI still clears irqActive.
- Flags are cleared only by resetN or OP_RESET.
- Reset asserted mid-operation discards any in-flight update; the first enabled edge after release executes from RESET_VECTOR.

Test Plan:
- Reset, then 3 cycles of opcode 15 with enable=1 -> pc 0,1,2,3; stackCount=0.
- At pc=5: OP_CALL target 0x40, then OP_RET at 0x40 -> pc 0x40 then 6; stackCount 1 then 0.
- enable=0 for 4 cycles with OP_JUMP 0x80 and irq=1 applied -> pc, stackCount and irqActive unchanged. Raise enable -> interrupt is taken first: pc=0xF0, entry=old pc.
- At pc=0x10 with irq=1 and OP_JUMP 0x80 -> pc=0xF0, irqActive=1. OP_RETI -> pc=0x10, irqActive=0.
- Issue 17 OP_CALLs with STACK_DEPTH=16 -> stackOverflow=1 on the 17th, stackCount=16. Then issue 17 OP_RETs -> stackUnderflow=1 on the 17th, pc advances by 1. Then OP_RESET -> both flags 0, pc=0.
- pc=0xFF with a default opcode -> pc=0x00. OP_IF0JUMP with registerValue=0 -> target taken; with registerValue=3 -> pc+1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with return-address stack, stall,
// interrupt entry/RETI and sticky stack overflow/underflow flags.
module pc_sequencer #(
  parameter int PC_WIDTH       = 8,
  parameter int REGISTER_WIDTH = 8,
  parameter int OPCODE_WIDTH   = 4,
  parameter int STACK_DEPTH    = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(0),
  parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = PC_WIDTH'(8'hF0),
  parameter logic [OPCODE_WIDTH-1:0] OP_RESET    = OPCODE_WIDTH'(0),
  parameter logic [OPCODE_WIDTH-1:0] OP_JUMP     = OPCODE_WIDTH'(1),
  parameter logic [OPCODE_WIDTH-1:0] OP_CALL     = OPCODE_WIDTH'(2),
  parameter logic [OPCODE_WIDTH-1:0] OP_RET      = OPCODE_WIDTH'(3),
  parameter logic [OPCODE_WIDTH-1:0] OP_IF0JUMP  = OPCODE_WIDTH'(4),
  parameter logic [OPCODE_WIDTH-1:0] OP_IF1JUMP  = OPCODE_WIDTH'(5),
  parameter logic [OPCODE_WIDTH-1:0] OP_RETI     = OPCODE_WIDTH'(6),
  localparam int PTR_W = $clog2(STACK_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      enable,
  input  logic [OPCODE_WIDTH-1:0]   opcode,
  input  logic [PC_WIDTH-1:0]       instructionValue,
  input  logic [REGISTER_WIDTH-1:0] registerValue,
  input  logic                      irq,
  output logic [PC_WIDTH-1:0]       pc,
  output logic [CNT_W-1:0]          stackCount,
  output logic                      irqActive,
  output logic                      stackOverflow,
  output logic                      stackUnderflow
);

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_nx;
  logic [PC_WIDTH-1:0] push_val;
  logic [CNT_W-1:0]    cnt_nx;
  logic [PTR_W-1:0]    wr_idx;
  logic [PTR_W-1:0]    top_idx;
  logic act_nx, ovf_nx, unf_nx;
  logic full, empty;
  logic is_rst, take_irq, exec;
  logic do_jump, do_call, do_ret, do_reti;
  logic do_if0, do_if1;
  logic do_push, do_pop, wr_en;

  assign pc_inc  = pc + PC_WIDTH'(1);
  assign full    = stackCount == CNT_W'(STACK_DEPTH);
  assign empty   = stackCount == '0;
  assign wr_idx  = stackCount[PTR_W-1:0];
  assign top_idx = stackCount[PTR_W-1:0] - PTR_W'(1);

  // Interrupt entry preempts every opcode except soft reset.
  assign is_rst   = opcode == OP_RESET;
  assign take_irq = irq && !irqActive && !is_rst;
  assign exec     = !is_rst && !take_irq;

  assign do_jump = exec && opcode == OP_JUMP;
  assign do_call = exec && opcode == OP_CALL;
  assign do_ret  = exec && opcode == OP_RET;
  assign do_reti = exec && opcode == OP_RETI;
  assign do_if0  = exec && opcode == OP_IF0JUMP;
  assign do_if1  = exec && opcode == OP_IF1JUMP;

  assign do_push = take_irq || do_call;
  assign do_pop  = do_ret || do_reti;
  assign wr_en   = enable && do_push && !full;

  always_comb begin
    pc_nx    = pc_inc;
    push_val = pc_inc;
    cnt_nx   = stackCount;
    act_nx   = irqActive;
    ovf_nx   = stackOverflow;
    unf_nx   = stackUnderflow;
    unique case (1'b1)
      is_rst: begin
        pc_nx  = RESET_VECTOR;
        cnt_nx = '0;
        act_nx = 1'b0;
        ovf_nx = 1'b0;
        unf_nx = 1'b0;
      end
      take_irq: begin
        pc_nx    = IRQ_VECTOR;
        push_val = pc;
        act_nx   = 1'b1;
      end
      do_jump: pc_nx = instructionValue;
      do_call: pc_nx = instructionValue;
      do_if0: begin
        if (registerValue == '0)
          pc_nx = instructionValue;
      end
      do_if1: begin
        if (registerValue != '0)
          pc_nx = instructionValue;
      end
      do_reti: act_nx = 1'b0;
      default: ;
    endcase
    if (do_push) begin
      if (full) ovf_nx = 1'b1;
      else      cnt_nx = stackCount + CNT_W'(1);
    end
    // An empty pop falls through to pc+1.
    if (do_pop) begin
      if (empty) begin
        unf_nx = 1'b1;
      end else begin
        pc_nx  = stack_mem[top_idx];
        cnt_nx = stackCount - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc             <= RESET_VECTOR;
      stackCount     <= '0;
      irqActive      <= 1'b0;
      stackOverflow  <= 1'b0;
      stackUnderflow <= 1'b0;
    end else if (enable) begin
      pc             <= pc_nx;
      stackCount     <= cnt_nx;
      irqActive      <= act_nx;
      stackOverflow  <= ovf_nx;
      stackUnderflow <= unf_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en)
      stack_mem[wr_idx] <= push_val;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed steps plus random traffic,
// checked against a queue-based reference model.
module tb_pc_sequencer;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [7:0] instructionValue = 8'd0;
  logic [7:0] registerValue = 8'd0;
  logic       irq = 1'b0;
  logic [7:0] pc;
  logic [4:0] stackCount;
  logic       irqActive;
  logic       stackOverflow;
  logic       stackUnderflow;

  pc_sequencer dut (
    .clock(clock),
    .resetN(resetN),
    .enable(enable),
    .opcode(opcode),
    .instructionValue(instructionValue),
    .registerValue(registerValue),
    .irq(irq),
    .pc(pc),
    .stackCount(stackCount),
    .irqActive(irqActive),
    .stackOverflow(stackOverflow),
    .stackUnderflow(stackUnderflow)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_act, m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".cnt"}, 32'(stackCount), 32'(m_stk.size()));
    chk({tag, ".act"}, 32'(irqActive), 32'(m_act));
    chk({tag, ".ovf"}, 32'(stackOverflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(stackUnderflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    m_stk.delete();
    m_act = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] v);
    if (m_stk.size() == 16) m_ovf = 1'b1;
    else m_stk.push_back(v);
  endtask

  task automatic model_pop();
    if (m_stk.size() == 0) begin
      m_unf = 1'b1;
      m_pc = m_pc + 8'd1;
    end else begin
      m_pc = m_stk.pop_back();
    end
  endtask

  task automatic model_step(input logic en, input logic [3:0] op,
                            input logic [7:0] iv, input logic [7:0] rv,
                            input logic ir);
    if (!en) return;
    if (op == 4'd0) begin
      model_reset();
    end else if (ir && !m_act) begin
      model_push(m_pc);
      m_pc = 8'hF0;
      m_act = 1'b1;
    end else begin
      case (op)
        4'd1: m_pc = iv;
        4'd2: begin model_push(m_pc + 8'd1); m_pc = iv; end
        4'd3: model_pop();
        4'd4: m_pc = (rv == 0) ? iv : m_pc + 8'd1;
        4'd5: m_pc = (rv != 0) ? iv : m_pc + 8'd1;
        4'd6: begin model_pop(); m_act = 1'b0; end
        default: m_pc = m_pc + 8'd1;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic en,
                      input logic [3:0] op, input logic [7:0] iv,
                      input logic [7:0] rv, input logic ir);
    enable = en;
    opcode = op;
    instructionValue = iv;
    registerValue = rv;
    irq = ir;
    model_step(en, op, iv, rv, ir);
    @(posedge clock);
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [7:0] held_pc;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk_all("areset");
    resetN = 1'b1;

    for (int i = 0; i < 3; i++) step("adv", 1, 4'd15, 8'h00, 8'h00, 0);
    chk("adv3", 32'(pc), 32'h3);

    step("j5", 1, 4'd1, 8'h05, 8'h00, 0);
    step("call", 1, 4'd2, 8'h40, 8'h00, 0);
    chk("call.pc", 32'(pc), 32'h40);
    chk("call.cnt", 32'(stackCount), 32'd1);
    step("ret", 1, 4'd3, 8'h00, 8'h00, 0);
    chk("ret.pc", 32'(pc), 32'h6);

    for (int i = 0; i < 4; i++) step("stall", 0, 4'd1, 8'h80, 8'h00, 1);
    chk("stall.pc", 32'(pc), 32'h6);
    step("irq1", 1, 4'd1, 8'h80, 8'h00, 1);
    chk("irq1.pc", 32'(pc), 32'hF0);
    step("irq1.nest", 1, 4'd15, 8'h00, 8'h00, 1);
    step("reti1", 1, 4'd6, 8'h00, 8'h00, 0);
    chk("reti1.pc", 32'(pc), 32'h6);

    step("j10", 1, 4'd1, 8'h10, 8'h00, 0);
    step("irq2", 1, 4'd1, 8'h80, 8'h00, 1);
    chk("irq2.act", 32'(irqActive), 32'd1);
    step("reti2", 1, 4'd6, 8'h00, 8'h00, 0);
    chk("reti2.pc", 32'(pc), 32'h10);

    for (int i = 0; i < 17; i++) step("call17", 1, 4'd2, 8'h20, 8'h00, 0);
    chk("ovf.flag", 32'(stackOverflow), 32'd1);
    chk("ovf.cnt", 32'(stackCount), 32'd16);
    for (int i = 0; i < 17; i++) step("ret17", 1, 4'd3, 8'h00, 8'h00, 0);
    chk("unf.flag", 32'(stackUnderflow), 32'd1);
    chk("unf.pc", 32'(pc), 32'h12);
    step("srst", 1, 4'd0, 8'h55, 8'h00, 1);
    chk("srst.flags", 32'({stackOverflow, stackUnderflow}), 32'd0);

    step("jff", 1, 4'd1, 8'hFF, 8'h00, 0);
    step("wrap", 1, 4'd9, 8'h00, 8'h00, 0);
    chk("wrap.pc", 32'(pc), 32'h0);
    step("if0t", 1, 4'd4, 8'h33, 8'h00, 0);
    step("if0n", 1, 4'd4, 8'h77, 8'h03, 0);
    chk("if0n.pc", 32'(pc), 32'h34);
    step("if1t", 1, 4'd5, 8'h90, 8'h01, 0);
    step("if1n", 1, 4'd5, 8'h20, 8'h00, 0);

    step("irq3", 1, 4'd15, 8'h00, 8'h00, 1);
    step("ret.inirq", 1, 4'd3, 8'h00, 8'h00, 0);
    step("reti.empty", 1, 4'd6, 8'h00, 8'h00, 0);
    chk("reti.empty.act", 32'(irqActive), 32'd0);

    // Async reset between edges must discard the pending update.
    step("pre", 1, 4'd2, 8'h70, 8'h00, 0);
    opcode = 4'd1;
    instructionValue = 8'hAA;
    #2 resetN = 1'b0;
    model_reset();
    #1 chk_all("mid.reset");
    resetN = 1'b1;
    step("post", 1, 4'd15, 8'h00, 8'h00, 0);
    chk("post.pc", 32'(pc), 32'h1);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 40) == 0) op = 4'd0;
      step("rand", ($urandom_range(0, 3) != 0), op,
           8'($urandom), 8'($urandom_range(0, 2)),
           ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 150) == 0) begin
        held_pc = 8'($urandom);
        instructionValue = held_pc;
        #2 resetN = 1'b0;
        model_reset();
        #1 chk_all("rand.areset");
        resetN = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
